// File: rtl/xosera_bus_master.sv
// xosera_bus_master: CPU-side initiator for the Xosera 8-bit register bus.
// Splits one 16-bit request into timed even/odd byte strobes.
module xosera_bus_master #(
  parameter int unsigned CS_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  req_reg_i,
  input  logic [1:0]  req_be_i,
  input  logic [15:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [15:0] resp_rdata_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  input  logic [7:0]  bus_data_i
);

  localparam int unsigned MAXC =
    (CS_CYCLES > GAP_CYCLES) ? CS_CYCLES : GAP_CYCLES;
  localparam int unsigned CW =
    (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RESP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic            odd_q;
  logic            odd_n;

  logic            we_q;
  logic [3:0]      reg_q;
  logic [15:0]     wdata_q;
  logic            two_q;

  logic            accept;

  logic            cs_n_d;
  logic            rd_nwr_d;
  logic [3:0]      reg_d;
  logic            bsel_d;
  logic [7:0]      data_d;
  logic            resp_d;
  logic [15:0]     rdata_d;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  // State, dwell counter and current-byte flag
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      odd_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      odd_q <= odd_n;
    end
  end

  // Request capture; only updated on accept so a held
  // valid cannot disturb a transaction in flight
  always_ff @(posedge clk) begin
    if (reset_i) begin
      we_q    <= 1'b0;
      reg_q   <= 4'h0;
      wdata_q <= 16'h0;
      two_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we_i;
      reg_q   <= req_reg_i;
      wdata_q <= req_wdata_i;
      two_q   <= &req_be_i;
    end
  end

  // Next-state: counter reloads on every state entry
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    odd_n   = odd_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          odd_n = ~req_be_i[1];
          if (req_be_i == 2'b00) begin
            state_n = RESP;
          end else begin
            state_n = SETUP;
          end
        end
      end
      SETUP: begin
        state_n = STROBE;
        cnt_n   = CW'(CS_CYCLES - 1);
      end
      STROBE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = CW'(GAP_CYCLES - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (!odd_q && two_q) begin
            state_n = SETUP;
            odd_n   = 1'b1;
          end else begin
            state_n = RESP;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output decode; read byte is captured on the edge
  // where the strobe is about to release
  always_comb begin
    cs_n_d   = 1'b1;
    rd_nwr_d = bus_rd_nwr_o;
    reg_d    = bus_reg_num_o;
    bsel_d   = bus_bytesel_o;
    data_d   = bus_data_o;
    resp_d   = 1'b0;
    rdata_d  = resp_rdata_o;
    unique case (state)
      SETUP, STROBE, HOLD: begin
        cs_n_d   = (state != STROBE);
        rd_nwr_d = ~we_q;
        reg_d    = reg_q;
        bsel_d   = odd_q;
        if (!we_q) begin
          data_d = 8'h00;
        end else if (odd_q) begin
          data_d = wdata_q[7:0];
        end else begin
          data_d = wdata_q[15:8];
        end
      end
      RESP: begin
        resp_d = 1'b1;
      end
      default: begin
      end
    endcase
    if (accept) begin
      rdata_d = 16'h0;
    end else if (bus_rd_nwr_o && !bus_cs_n_o && cs_n_d) begin
      if (bus_bytesel_o) begin
        rdata_d[7:0] = bus_data_i;
      end else begin
        rdata_d[15:8] = bus_data_i;
      end
    end
  end

  // Registered bus and response outputs
  always_ff @(posedge clk) begin
    if (reset_i) begin
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_reg_num_o <= 4'h0;
      bus_bytesel_o <= 1'b0;
      bus_data_o    <= 8'h00;
      resp_valid_o  <= 1'b0;
      resp_rdata_o  <= 16'h0;
    end else begin
      bus_cs_n_o    <= cs_n_d;
      bus_rd_nwr_o  <= rd_nwr_d;
      bus_reg_num_o <= reg_d;
      bus_bytesel_o <= bsel_d;
      bus_data_o    <= data_d;
      resp_valid_o  <= resp_d;
      resp_rdata_o  <= rdata_d;
    end
  end

endmodule

// File: doc/xosera_bus_master.md
Name: xosera_bus_master

Overview:
- CPU-side initiator for the Xosera 8-bit register bus: the side that drives cs_n/rd_nwr/reg_num/bytesel/data into xosera_main.
- Converts one 16-bit register read/write request (valid/ready) into up to two timed byte strobes: even byte = bits [15:8] first, then odd byte = bits [7:0].
- Returns a single-cycle response carrying read data.
- Sits between the SoC interconnect and the xga video/audio block.

Parameters:
- CS_CYCLES, 4, cycles cs_n_o held low per byte strobe; legal values >= 2.
- GAP_CYCLES, 2, cycles cs_n_o held high after each strobe, with address/data still driven; legal values >= 1.

Ports:
- clk  input  1  system clock, same clock as xosera_main
- reset_i  input  1  synchronous active-high reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  block can accept a request
- req_we_i  input  1  1 = write, 0 = read
- req_reg_i  input  4  Xosera register number
- req_be_i  input  2  byte enables; bit1 = even byte [15:8], bit0 = odd byte [7:0]
- req_wdata_i  input  16  write data
- resp_valid_o  output  1  one-cycle completion pulse, for reads and writes
- resp_rdata_o  output  16  read data; disabled bytes read as 0x00
- bus_cs_n_o  output  1  register select strobe, active low
- bus_rd_nwr_o  output  1  1 = read, 0 = write
- bus_reg_num_o  output  4  register number
- bus_bytesel_o  output  1  0 = even byte, 1 = odd byte
- bus_data_o  output  8  write byte
- bus_data_i  input  8  read byte from xosera_main

Behaviour:
- All outputs are registered except req_ready_o, which equals (state == IDLE).
- Reset values:
  - bus_cs_n_o = 1, bus_rd_nwr_o = 1, bus_reg_num_o = 0, bus_bytesel_o = 0, bus_data_o = 0
  - resp_valid_o = 0, resp_rdata_o = 0
  - state = IDLE, so req_ready_o = 1 on the cycle after reset.
- Reset asserted mid-transaction aborts at the next edge: cs_n_o returns high, no response is issued, and the request is dropped.
- Accept: on an edge with req_valid_i && req_ready_o, latch we, reg, be and wdata. The first enabled byte is even if be[1], else odd.
- States:
  - IDLE
  - SETUP (1 cycle): cs_n high; reg_num, bytesel, rd_nwr and data_o valid.
  - STROBE (CS_CYCLES): cs_n low; all other bus outputs stable.
  - HOLD (GAP_CYCLES): cs_n high; outputs still stable.
  - RESP (1 cycle): resp_valid_o = 1.
- Transitions:
  - IDLE -> SETUP on accept.
  - SETUP -> STROBE -> HOLD.
  - HOLD -> SETUP if the odd byte is still pending, else RESP.
  - RESP -> IDLE.
- be = 00: IDLE -> RESP directly. resp_valid_o is asserted on the cycle after the accept edge; no bus strobe occurs.
- Reads:
  - bus_rd_nwr_o = 1 and bus_data_o = 0.
  - bus_data_i is sampled on the edge that ends the final STROBE cycle.
  - The sample goes into the even (high) or odd (low) half of resp_rdata_o.
  - resp_rdata_o is cleared on accept and held after RESP until the next accept.
- Writes: bus_data_o = wdata[15:8] for the even byte, wdata[7:0] for the odd byte; resp_rdata_o = 0.
- Latency from the accept edge to the resp_valid_o rising edge: n × (1 + CS_CYCLES + GAP_CYCLES) + 1, where n = number of enabled bytes. With the defaults: 15 cycles for two bytes, 8 for one, 1 for none.
- Within a transaction, cs_n never goes low on two consecutive strobes without at least GAP_CYCLES + 1 high cycles between them.
- A new request can be accepted on the cycle after RESP (IDLE). Back-to-back throughput is therefore latency + 1 cycles.
- req_* inputs are ignored while req_ready_o = 0; a held req_valid_i does not restart or corrupt the transaction in progress.
- A counter sized to max(CS_CYCLES, GAP_CYCLES) must not wrap: it reloads on every state entry.

Test Plan:
- Write reg 3, be = 11, wdata = 0xA55A, defaults -> two strobes, each cs_n low for exactly 4 cycles:
  - first strobe: bytesel = 0, data = 0xA5; second: bytesel = 1, data = 0x5A
  - rd_nwr = 0 and reg_num = 3 on both
  - resp_valid pulse 15 cycles after accept.
- Read reg 9, be = 11, with a bus model returning 0x12 (even) and 0x34 (odd) during strobe -> resp_rdata_o = 0x1234, rd_nwr = 1, data_o = 0, resp 15 cycles after accept.
- Byte enables:
  - read be = 01, odd returns 0xCD -> single strobe with bytesel = 1, resp_rdata_o = 0x00CD, resp at 8 cycles
  - be = 00 -> no cs_n activity, resp at 1 cycle.
- Reset asserted during the 2nd cycle of the first strobe -> cs_n_o = 1 on the next edge, no resp_valid_o, req_ready_o = 1 after reset. A following write completes normally.
- Back-to-back: req_valid_i held high with two writes queued -> second accepted exactly on the cycle after the first resp_valid_o. cs_n high for ≥ 3 cycles between strobes.
- Parameter sweep CS_CYCLES = 2, GAP_CYCLES = 1 -> strobe width 2, latency 9 for two bytes, correct data.
